// File: rtl/corrige_hamming_param.sv
// corrige_hamming_param: two-stage valid/ready Hamming decoder with single-error correction and error counters.
// Define CORRIGE_HAMMING_SECDED_EN to add the overall parity bit and double-error detection.
`timescale 1ns/1ps
module corrige_hamming_param #(
  parameter int R = 4,
  localparam int N = (1 << R) - 1,
  localparam int K = N - R,
`ifdef CORRIGE_HAMMING_SECDED_EN
  localparam int W = N + 1
`else
  localparam int W = N
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] entrada,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] saida,
  output logic [R-1:0] sindrome,
  output logic         erro_corrigido,
  output logic         erro_duplo,
  input  logic         clr_cnt,
  output logic [15:0]  cnt_corrigidos,
  output logic [15:0]  cnt_duplos
);
  logic         s1_valid_q, out_valid_q, ec_q, s2_load, s1_load, flip, ec_d;
  logic [N-1:0] s1_word_q, mask, fix;
  logic [R-1:0] s1_syn_q, syn_d, sind_q;
  logic [K-1:0] dat_d, saida_q;
  logic [15:0]  cnt_c_q, cnt_c_d;
  assign s2_load = !out_valid_q || out_ready;
  assign s1_load = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_valid = out_valid_q;
  assign saida = saida_q;
  assign sindrome = sind_q;
  assign erro_corrigido = ec_q;
  assign cnt_corrigidos = cnt_c_q;
  always_comb begin
    syn_d = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < R; j++)
        if ((((i + 1) >> j) & 1) == 1) syn_d[j] = syn_d[j] ^ entrada[i];
  end
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = (s1_syn_q == R'(i + 1));
  end
  assign fix = s1_word_q ^ (flip ? mask : '0);
  // Data bits sit at the non-power-of-two positions, packed in ascending order.
  always_comb begin
    int k;
    dat_d = '0;
    k = 0;
    for (int i = 0; i < N; i++)
      if ((((i + 1) & i)) != 0) begin
        dat_d[k] = fix[i];
        k = k + 1;
      end
  end
  assign cnt_c_d = clr_cnt ? 16'h0 :
                   (out_valid_q && out_ready && ec_q && cnt_c_q != 16'hFFFF) ? cnt_c_q + 16'h1 : cnt_c_q;
`ifdef CORRIGE_HAMMING_SECDED_EN
  logic        s1_par_q, ed_q, ed_d;
  logic [15:0] cnt_d_q, cnt_d_d;
  // Odd overall parity means an odd number of flips: one, and correctable.
  assign flip = s1_par_q;
  assign ec_d = s1_par_q;
  assign ed_d = (s1_syn_q != '0) && !s1_par_q;
  assign erro_duplo = ed_q;
  assign cnt_duplos = cnt_d_q;
  assign cnt_d_d = clr_cnt ? 16'h0 :
                   (out_valid_q && out_ready && ed_q && cnt_d_q != 16'hFFFF) ? cnt_d_q + 16'h1 : cnt_d_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_par_q <= 1'b0;
      ed_q     <= 1'b0;
      cnt_d_q  <= '0;
    end else begin
      if (s1_load && in_valid) s1_par_q <= ^entrada;
      if (s2_load && s1_valid_q) ed_q <= ed_d;
      cnt_d_q <= cnt_d_d;
    end
`else
  assign ec_d = (s1_syn_q != '0);
  assign flip = ec_d;
  assign erro_duplo = 1'b0;
  assign cnt_duplos = 16'h0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      s1_syn_q    <= '0;
      out_valid_q <= 1'b0;
      saida_q     <= '0;
      sind_q      <= '0;
      ec_q        <= 1'b0;
      cnt_c_q     <= '0;
    end else begin
      if (s1_load) s1_valid_q <= in_valid;
      if (s1_load && in_valid) begin
        s1_word_q <= entrada[N-1:0];
        s1_syn_q  <= syn_d;
      end
      if (s2_load) out_valid_q <= s1_valid_q;
      if (s2_load && s1_valid_q) begin
        saida_q <= dat_d;
        sind_q  <= s1_syn_q;
        ec_q    <= ec_d;
      end
      cnt_c_q <= cnt_c_d;
    end
endmodule

// File: tb/tb_corrige_hamming_param.sv
// tb_corrige_hamming_param: directed vector table plus backpressure, saturation, clear and reset sequences (R=4).
`timescale 1ns/1ps
module tb_corrige_hamming_param;
  localparam int R = 4;
  localparam int K = 11;
`ifdef CORRIGE_HAMMING_SECDED_EN
  localparam int W = 16;
`else
  localparam int W = 15;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, clr_cnt = 1'b0;
  logic [W-1:0] entrada = '0;
  logic in_ready, out_valid, erro_corrigido, erro_duplo;
  logic [K-1:0] saida;
  logic [R-1:0] sindrome;
  logic [15:0] cnt_corrigidos, cnt_duplos;
  int n_tests = 0, n_fail = 0, exp_c = 0, exp_d = 0;

  corrige_hamming_param #(.R(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .entrada(entrada),
    .out_valid(out_valid), .out_ready(out_ready), .saida(saida), .sindrome(sindrome),
    .erro_corrigido(erro_corrigido), .erro_duplo(erro_duplo), .clr_cnt(clr_cnt),
    .cnt_corrigidos(cnt_corrigidos), .cnt_duplos(cnt_duplos)
  );

  always #5 clk = ~clk;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [15:0] w;
    logic [10:0] d;
    logic [3:0]  s;
    logic        c;
    logic        e;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [14:0] c);
`ifdef CORRIGE_HAMMING_SECDED_EN
    return {^c, c};
`else
    return {1'b0, c};
`endif
  endfunction

  task automatic apply(input vec_t v);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    entrada = v.w[W-1:0];
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    chk("latency", 32'(lat), 32'd2);
    chk("saida", 32'(saida), 32'(v.d));
    chk("sindrome", 32'(sindrome), 32'(v.s));
    chk("erro_corrigido", 32'(erro_corrigido), 32'(v.c));
    chk("erro_duplo", 32'(erro_duplo), 32'(v.e));
    if (v.c) exp_c++;
    if (v.e) exp_d++;
    @(negedge clk);
    chk("cnt_corrigidos", 32'(cnt_corrigidos), 32'(exp_c));
    chk("cnt_duplos", 32'(cnt_duplos), 32'(exp_d));
  endtask

  initial begin
    logic [15:0] bw[4];
    logic [10:0] bd[4];
    logic [10:0] held;
    logic hv, acc;
    int sent, got, first;
`ifdef CORRIGE_HAMMING_SECDED_EN
    tv.push_back({16'h0000, 11'h000, 4'd0,  1'b0, 1'b0});
    tv.push_back({16'hFFFF, 11'h7FF, 4'd0,  1'b0, 1'b0});
    tv.push_back({16'hFFFC, 11'h7FF, 4'd3,  1'b0, 1'b1});
    tv.push_back({16'h8000, 11'h000, 4'd0,  1'b1, 1'b0});
    tv.push_back({16'h0020, 11'h000, 4'd6,  1'b1, 1'b0});
    tv.push_back({16'h8007, 11'h001, 4'd0,  1'b0, 1'b0});
    tv.push_back({16'h8047, 11'h001, 4'd7,  1'b1, 1'b0});
    tv.push_back({16'h0060, 11'h00C, 4'd1,  1'b0, 1'b1});
`else
    tv.push_back({16'h0000, 11'h000, 4'd0,  1'b0, 1'b0});
    tv.push_back({16'h7FFF, 11'h7FF, 4'd0,  1'b0, 1'b0});
    tv.push_back({16'h0020, 11'h000, 4'd6,  1'b1, 1'b0});
    tv.push_back({16'h7FFE, 11'h7FF, 4'd1,  1'b1, 1'b0});
    tv.push_back({16'h0004, 11'h000, 4'd3,  1'b1, 1'b0});
    tv.push_back({16'h4000, 11'h000, 4'd15, 1'b1, 1'b0});
    tv.push_back({16'h0007, 11'h001, 4'd0,  1'b0, 1'b0});
    tv.push_back({16'h0047, 11'h001, 4'd7,  1'b1, 1'b0});
    tv.push_back({16'h0019, 11'h002, 4'd0,  1'b0, 1'b0});
`endif
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_saida", 32'(saida), 32'd0);
    chk("rst_sindrome", 32'(sindrome), 32'd0);
    chk("rst_flags", 32'({erro_corrigido, erro_duplo}), 32'd0);
    chk("rst_counters", 32'({cnt_corrigidos, cnt_duplos}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) apply(tv[i]);

    bw[0] = mk(15'h0007); bd[0] = 11'h001;
    bw[1] = mk(15'h0019); bd[1] = 11'h002;
    bw[2] = mk(15'h7FFF); bd[2] = 11'h7FF;
    bw[3] = mk(15'h0000); bd[3] = 11'h000;
    sent = 0; got = 0; first = -1; hv = 1'b0; held = '0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid = (sent < 4);
      entrada = bw[sent < 4 ? sent : 3][W-1:0];
      #1;
      if (!in_ready && first < 0) first = sent;
      if (out_valid && !out_ready) begin
        if (!hv) begin
          held = saida;
          hv = 1'b1;
        end else chk("stall_hold", 32'(saida), 32'(held));
      end
      if (out_valid && out_ready) begin
        chk("bp_order", 32'(saida), 32'(bd[got]));
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    #1 in_valid = 1'b0;
    chk("bp_in_ready_drop", 32'(first), 32'd2);
    chk("bp_words_out", 32'(got), 32'd4);
    @(negedge clk);
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_cnt_c", 32'(cnt_corrigidos), 32'd0);
    chk("clr_cnt_d", 32'(cnt_duplos), 32'd0);
    exp_c = 0; exp_d = 0;
    entrada = W'(16'h0020);
    in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat_fffe", 32'(cnt_corrigidos), 32'hFFFE);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat_ffff", 32'(cnt_corrigidos), 32'hFFFF);

    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_hs_valid", 32'({out_valid, erro_corrigido}), 32'd3);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_priority", 32'(cnt_corrigidos), 32'd0);

    exp_c = 0;
    apply(tv[2]);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    entrada = mk(15'h0007)[W-1:0];
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_counters", 32'({cnt_corrigidos, cnt_duplos}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_dropped", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
